// File: rtl/lc3_instrmem_if.sv
// Fetch-side bus of the LC-3 instruction memory: read request, response and backdoor load.
interface lc3_instrmem_if;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic [15:0] instr_dout;
    logic        complete_instr;
    logic        busy;
    logic        addr_err;

    modport master (
        output pc, instrmem_rd, load_en, load_addr, load_data,
        input  instr_dout, complete_instr, busy, addr_err
    );

    modport slave (
        input  pc, instrmem_rd, load_en, load_addr, load_data,
        output instr_dout, complete_instr, busy, addr_err
    );
endinterface

// File: rtl/lc3_instrmem.sv
// LC-3 instruction memory responder: one 16-bit word per fetch request after LATENCY wait
// cycles, out-of-range reads return TRAP HALT with addr_err; backdoor load port for preloading.
module lc3_instrmem #(
    parameter logic [15:0] ADDR_BASE = 16'h3000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic            clock,
    input  logic            reset,
    lc3_instrmem_if.slave   mem_if
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = $clog2(LATENCY + 1);
    localparam logic [15:0] TRAP_HALT = 16'hF025;
    localparam logic [16:0] END_ADDR  = 17'(ADDR_BASE) + 17'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_e;

    function automatic logic in_range(input logic [15:0] a);
        return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [AW-1:0] to_idx(input logic [15:0] a);
        return AW'(a - ADDR_BASE);
    endfunction

    logic [15:0]   mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic          cmp_q, cmp_d;
    logic          err_q, err_d;
    logic [15:0]   rd_word;

    // Backdoor write; array is never cleared, reset only blocks a concurrent load.
    always_ff @(posedge clock) begin
        if (!reset && mem_if.load_en && in_range(mem_if.load_addr)) begin
            mem_q[to_idx(mem_if.load_addr)] <= mem_if.load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            cmp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
        end
    end

    // Array is read combinationally so a same-edge load is seen only by later reads.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        cmp_d   = 1'b0;
        err_d   = 1'b0;
        rd_word = mem_q[to_idx(addr_q)];
        case (state_q)
            IDLE: begin
                if (mem_if.instrmem_rd) begin
                    addr_d  = mem_if.pc;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                    cmp_d   = 1'b1;
                    err_d   = !in_range(addr_q);
                    dout_d  = in_range(addr_q) ? rd_word : TRAP_HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_if.instr_dout     = dout_q;
    assign mem_if.complete_instr = cmp_q;
    assign mem_if.addr_err       = err_q;
    assign mem_if.busy           = (state_q == WAIT);

endmodule

// File: tb/tb_lc3_instrmem.sv
// Self-checking bench for lc3_instrmem: per-cycle transaction-level reference model,
// directed vector table, hand-written corner sequences and a randomized phase.
module tb_lc3_instrmem;

    localparam int LATENCY = 2;
    localparam int BASE    = 'h3000;
    localparam int DEPTH   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lc3_instrmem_if bus();

    lc3_instrmem #(
        .ADDR_BASE(16'h3000),
        .DEPTH(DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clock (clk),
        .reset (rst),
        .mem_if(bus)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int ecnt   = 0;

    // Reference model: absolute-address memory image plus one outstanding request.
    logic [15:0] mem_m [0:65535];
    bit          pend = 1'b0;
    int          done_edge = 0;
    logic [15:0] paddr = '0;
    logic [15:0] e_dout = '0;
    bit          e_cmp = 1'b0, e_err = 1'b0;

    function automatic bit in_rng(input logic [15:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Advance one clock edge, update the model from the inputs present at the edge, compare.
    task automatic tick();
        logic r, rd, le;
        logic [15:0] p, la, ld;
        r  = rst;
        rd = bus.instrmem_rd;
        p  = bus.pc;
        le = bus.load_en;
        la = bus.load_addr;
        ld = bus.load_data;
        @(posedge clk);
        #1;
        ecnt++;
        e_cmp = 1'b0;
        e_err = 1'b0;
        if (r) begin
            pend   = 1'b0;
            e_dout = '0;
        end else begin
            if (pend) begin
                if (ecnt == done_edge) begin
                    pend  = 1'b0;
                    e_cmp = 1'b1;
                    if (in_rng(paddr)) e_dout = mem_m[paddr];
                    else begin
                        e_dout = 16'hF025;
                        e_err  = 1'b1;
                    end
                end
            end else if (rd) begin
                pend      = 1'b1;
                paddr     = p;
                done_edge = ecnt + LATENCY;
            end
            if (le && in_rng(la)) mem_m[la] = ld;
        end
        chk("dout", bus.instr_dout, e_dout);
        chk("complete", 16'(bus.complete_instr), 16'(e_cmp));
        chk("addr_err", 16'(bus.addr_err), 16'(e_err));
        chk("busy", 16'(bus.busy), 16'(pend));
    endtask

    task automatic wait_complete(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            n++;
            if (bus.complete_instr) ok = 1'b1;
        end
        ntests++;
        if (!ok) begin
            nfail++;
            $display("FAIL timeout: no complete_instr within %0d cycles", n);
        end
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output int n);
        bus.instrmem_rd = 1'b1;
        bus.pc          = a;
        tick();
        bus.instrmem_rd = 1'b0;
        wait_complete(n);
    endtask

    typedef struct {
        bit          ld;
        logic [15:0] la;
        logic [15:0] ldat;
        logic [15:0] pc;
        logic [15:0] exp_dout;
        bit          exp_err;
    } vec_t;

    vec_t vt [7];

    initial begin
        int n;
        int last;
        bus.pc = '0; bus.instrmem_rd = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        for (int a = 0; a < 65536; a++) mem_m[a] = '0;

        vt[0] = '{1'b1, 16'h3000, 16'h1234, 16'h3000, 16'h1234, 1'b0};
        vt[1] = '{1'b0, 16'h0000, 16'h0000, 16'h2FFF, 16'hF025, 1'b1};
        vt[2] = '{1'b0, 16'h0000, 16'h0000, 16'h3400, 16'hF025, 1'b1};
        vt[3] = '{1'b1, 16'h3400, 16'hBEEF, 16'h3000, 16'h1234, 1'b0};
        vt[4] = '{1'b1, 16'h33FF, 16'h5A5A, 16'h33FF, 16'h5A5A, 1'b0};
        vt[5] = '{1'b1, 16'h3001, 16'h0000, 16'h3001, 16'h0000, 1'b0};
        vt[6] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hF025, 1'b1};

        // Reset held two cycles with a pending request.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus.instrmem_rd = 1'b0;

        // Preload the whole array with random words so every read is defined.
        for (int a = 0; a < DEPTH; a++) do_load(16'(BASE + a), 16'($urandom));

        for (int i = 0; i < 7; i++) begin
            if (vt[i].ld) do_load(vt[i].la, vt[i].ldat);
            do_read(vt[i].pc, n);
            chk($sformatf("vec%0d_latency", i), 16'(n), 16'(LATENCY));
            chk($sformatf("vec%0d_dout", i), bus.instr_dout, vt[i].exp_dout);
            chk($sformatf("vec%0d_err", i), 16'(bus.addr_err), 16'(vt[i].exp_err));
            tick();
            chk($sformatf("vec%0d_hold", i), bus.instr_dout, vt[i].exp_dout);
        end

        // Back-to-back reads with instrmem_rd held high.
        for (int k = 0; k < 4; k++) do_load(16'(BASE + k), 16'(16'hA000 + k));
        bus.instrmem_rd = 1'b1;
        bus.pc = 16'h3000;
        last = ecnt;
        for (int k = 0; k < 4; k++) begin
            wait_complete(n);
            chk($sformatf("b2b%0d_data", k), bus.instr_dout, 16'(16'hA000 + k));
            if (k > 0) chk($sformatf("b2b%0d_spacing", k), 16'(ecnt - last), 16'(LATENCY + 1));
            last = ecnt;
            if (k == 3) bus.instrmem_rd = 1'b0;
            else bus.pc = 16'(16'h3001 + k);
        end
        tick();

        // Reset in the first WAIT cycle aborts the read.
        bus.instrmem_rd = 1'b1;
        bus.pc = 16'h3000;
        tick();
        bus.instrmem_rd = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 16'(bus.busy), 16'h0);
        chk("rst_mid_cmp", 16'(bus.complete_instr), 16'h0);
        do_read(16'h3000, n);
        chk("rst_mid_latency", 16'(n), 16'(LATENCY));
        chk("rst_mid_dout", bus.instr_dout, 16'hA000);

        // Load collides with the completing edge: read sees the old word.
        do_load(16'h3005, 16'h1111);
        bus.instrmem_rd = 1'b1;
        bus.pc = 16'h3005;
        tick();
        bus.instrmem_rd = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) tick();
        bus.load_en = 1'b1; bus.load_addr = 16'h3005; bus.load_data = 16'h2222;
        tick();
        bus.load_en = 1'b0;
        chk("coll_cmp", 16'(bus.complete_instr), 16'h1);
        chk("coll_old", bus.instr_dout, 16'h1111);
        do_read(16'h3005, n);
        chk("coll_new", bus.instr_dout, 16'h2222);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.instrmem_rd = $urandom_range(0, 1);
            bus.pc = ($urandom_range(0, 7) == 0) ? 16'($urandom_range('h2FF0, 'h3410))
                                                 : 16'(BASE + $urandom_range(0, DEPTH - 1));
            bus.load_en = ($urandom_range(0, 3) == 0);
            bus.load_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                        : 16'(BASE + $urandom_range(0, DEPTH - 1));
            bus.load_data = 16'($urandom);
            tick();
        end
        rst = 1'b0;
        bus.instrmem_rd = 1'b0;
        bus.load_en = 1'b0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
